display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed driver for an 8-digit, common-anode, seven-segment display.
// Every digit gets one slot: BLANK_CYCLES of dead time with all anodes off,
// followed by DRIVE_CYCLES with that digit's anode on. The slots run from the
// rightmost digit (d1) to the leftmost (d8), then the frame repeats.
//
// The descriptor for a digit is captured when its DRIVE phase begins. Input
// changes during DRIVE therefore show up the next time that digit is scanned.
//
// Parameters
//   BLANK_CYCLES  dead-time cycles before each digit slot (>= 1)
//   DRIVE_CYCLES  cycles each digit is driven              (>= 1)
//
// Ports
//   clk_100MHz_i  sole clock; all logic runs on the rising edge
//   reset_i       synchronous, active-high reset
//   d1..d8        digit descriptors {enable, value[3:0], dp_n}; d1 is rightmost
//   lamp_test_i   forces all segments and the decimal point on while driving
//   an_o          active-low anode selects; an_o[k] drives digit d(k+1)
//   seg_o         active-low segments; seg_o[0]=a through seg_o[6]=g
//   dp_o          active-low decimal point
//   frame_o       one-cycle pulse on the first cycle of each 8-digit frame
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int BLANK_CYCLES = 1000,
  parameter int DRIVE_CYCLES = 99000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic       lamp_test_i,
  output logic [7:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       frame_o
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  // The counter only has to reach the longer of the two phase lengths minus one.
  localparam int MAX_CYC = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Descriptor field positions.
  localparam int EN_BIT  = 5;
  localparam int DPN_BIT = 0;

  // Hex digit to active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // FSM and datapath state.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [5:0]       hold_q,  hold_d;
  // Clear for exactly the first cycle out of reset. That edge must present
  // cycle 0 of the frame (BLANK, count 0) rather than advance past it.
  logic             armed_q, armed_d;

  // Registered outputs.
  logic [7:0] an_q,    an_d;
  logic [6:0] seg_q,   seg_d;
  logic       dp_q,    dp_d;
  logic       frame_q, frame_d;

  logic [5:0] d_sel;

  // Descriptor of the digit whose slot is in progress.
  always_comb begin
    case (idx_q)
      3'd0:    d_sel = d1;
      3'd1:    d_sel = d2;
      3'd2:    d_sel = d3;
      3'd3:    d_sel = d4;
      3'd4:    d_sel = d5;
      3'd5:    d_sel = d6;
      3'd6:    d_sel = d7;
      default: d_sel = d8;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: every flop uses non-blocking assignment, so all registers sample the
  // values from before the edge, whatever order the statements are written in.
  always_ff @(posedge clk_100MHz_i) begin
    if (reset_i) begin
      // NOTE: the holding register is a plain flop, not memory, so it is
      // cleared along with the rest of the state.
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      armed_q <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      armed_q <= armed_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    armed_d = 1'b1;

    if (armed_q) begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
            hold_d  = d_sel;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;  // 7 wraps to 0
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // Built from the next state, so the registered outputs match the FSM state
  // in the cycle where they appear.
  always_comb begin
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    frame_d = (state_d == ST_BLANK) && (cnt_d == '0) && (idx_d == 3'd0);

    if (state_d == ST_DRIVE) begin
      if (lamp_test_i) begin
        an_d[idx_d] = 1'b0;
        seg_d       = 7'h00;
        dp_d        = 1'b0;
      end else if (hold_d[EN_BIT]) begin
        an_d[idx_d] = 1'b0;
        seg_d       = hex_to_seg(hold_d[4:1]);
        dp_d        = hold_d[DPN_BIT];
      end
    end
  end

  assign an_o    = an_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for display_scan_ctrl with BLANK_CYCLES=2, DRIVE_CYCLES=4.
// A slot is 6 cycles (BLANK 6k..6k+1, DRIVE 6k+2..6k+5) and a frame is 48.
// Stimulus pushes {tick, expected outputs} entries into a queue. A negedge
// monitor pops and compares the entry for the current tick, and it checks on
// every cycle that no more than one anode is low.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic       lamp_test_i = 1'b0;
  logic [7:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;
  logic       frame_o;

  display_scan_ctrl #(
    .BLANK_CYCLES(2),
    .DRIVE_CYCLES(4)
  ) dut (
    .clk_100MHz_i(clk),
    .reset_i     (reset_i),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .d5          (d5),
    .d6          (d6),
    .d7          (d7),
    .d8          (d8),
    .lamp_test_i (lamp_test_i),
    .an_o        (an_o),
    .seg_o       (seg_o),
    .dp_o        (dp_o),
    .frame_o     (frame_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    logic [16:0] v;   // {an, seg, dp, frame}
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tick = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Segment codes for 0..F, written out from the decode table.
  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always @(posedge clk) tick <= tick + 1;

  function automatic logic [5:0] mk(input logic en, input logic [3:0] val, input logic dpn);
    return {en, val, dpn};
  endfunction

  task automatic check(input string nm, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s tick %0d: got an=%h seg=%h dp=%b fr=%b, expected an=%h seg=%h dp=%b fr=%b",
               nm, tick, got[16:9], got[8:2], got[1], got[0],
               want[16:9], want[8:2], want[1], want[0]);
    end
  endtask

  task automatic push(input int t, input logic [7:0] an, input logic [6:0] seg,
                      input logic dp, input logic fr, input string nm);
    exp_t e;
    e.t  = t;
    e.v  = {an, seg, dp, fr};
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compares against the scoreboard away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ($countones(~an_o) > 1) begin
        errors++;
        $display("FAIL an_onehot tick %0d: got an=%h, expected at most one low bit", tick, an_o);
      end
      while (exp_q.size() > 0 && exp_q[0].t <= tick) begin
        mon_e = exp_q.pop_front();
        if (mon_e.t < tick) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for tick %0d not compared, now tick %0d", mon_e.nm, mon_e.t, tick);
        end else begin
          check(mon_e.nm, {an_o, seg_o, dp_o, frame_o}, mon_e.v);
        end
      end
    end
  end

  task automatic wait_tick(input int t);
    while (tick < t) @(negedge clk);
  endtask

  // Reset pulse, checking the idle output state while reset is held.
  // Returns the tick of cycle 0, the first cycle after release.
  task automatic start_run(output int base);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    push(tick + 1, 8'hFF, 7'h7F, 1'b1, 1'b0, "reset_state");
    @(negedge clk);
    reset_i = 1'b0;
    base = tick + 1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_all_enabled();
    d1 = mk(1'b1, 4'd1, 1'b1);
    d2 = mk(1'b1, 4'd2, 1'b1);
    d3 = mk(1'b1, 4'd3, 1'b1);
    d4 = mk(1'b1, 4'd4, 1'b1);
    d5 = mk(1'b1, 4'd5, 1'b1);
    d6 = mk(1'b1, 4'd6, 1'b1);
    d7 = mk(1'b1, 4'd7, 1'b1);
    d8 = mk(1'b1, 4'd8, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tick %0d", tick);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int base2;
    set_all_enabled();

    // Basic scan, frame timing and a disabled digit (d3).
    d3 = mk(1'b0, 4'd5, 1'b1);
    start_run(base);
    push(base + 0, 8'hFF, 7'h7F, 1'b1, 1'b1, "a_frame0");
    push(base + 1, 8'hFF, 7'h7F, 1'b1, 1'b0, "a_blank1");
    for (int c = 2; c <= 5; c++)   push(base + c, 8'hFE, 7'h79, 1'b1, 1'b0, "a_d1");
    for (int c = 8; c <= 11; c++)  push(base + c, 8'hFD, 7'h24, 1'b1, 1'b0, "a_d2");
    for (int c = 12; c <= 13; c++) push(base + c, 8'hFF, 7'h7F, 1'b1, 1'b0, "a_blank_idx2");
    for (int c = 14; c <= 17; c++) push(base + c, 8'hFF, 7'h7F, 1'b1, 1'b0, "a_disabled_d3");
    for (int c = 20; c <= 23; c++) push(base + c, 8'hF7, 7'h19, 1'b1, 1'b0, "a_d4");
    push(base + 47, 8'h7F, 7'h00, 1'b1, 1'b0, "a_d8");
    push(base + 48, 8'hFF, 7'h7F, 1'b1, 1'b1, "a_frame1");
    push(base + 49, 8'hFF, 7'h7F, 1'b1, 1'b0, "a_frame1_next");
    push(base + 50, 8'hFE, 7'h79, 1'b1, 1'b0, "a_wrap_d1");
    push(base + 96, 8'hFF, 7'h7F, 1'b1, 1'b1, "a_frame2");
    drain();

    // Input change mid-DRIVE is held off until the next capture.
    set_all_enabled();
    d1 = mk(1'b1, 4'd3, 1'b1);
    start_run(base);
    for (int c = 2; c <= 5; c++)   push(base + c, 8'hFE, 7'h30, 1'b1, 1'b0, "b_hold_old");
    for (int c = 50; c <= 53; c++) push(base + c, 8'hFE, 7'h00, 1'b0, 1'b0, "b_next_frame");
    wait_tick(base + 3);
    d1 = mk(1'b1, 4'd8, 1'b0);
    drain();

    // Lamp test overrides a disabled digit; BLANK stays dark.
    set_all_enabled();
    d5 = mk(1'b0, 4'd9, 1'b1);
    lamp_test_i = 1'b1;
    start_run(base);
    push(base + 0, 8'hFF, 7'h7F, 1'b1, 1'b1, "c_frame0");
    push(base + 2, 8'hFE, 7'h00, 1'b0, 1'b0, "c_lamp_d1");
    for (int c = 24; c <= 25; c++) push(base + c, 8'hFF, 7'h7F, 1'b1, 1'b0, "c_lamp_blank");
    for (int c = 26; c <= 29; c++) push(base + c, 8'hEF, 7'h00, 1'b0, 1'b0, "c_lamp_d5");
    drain();
    lamp_test_i = 1'b0;

    // Decode of all 16 values: 0..7 in frame 0, 8..F (dp on) in frame 1.
    d1 = mk(1'b1, 4'h0, 1'b1);
    d2 = mk(1'b1, 4'h1, 1'b1);
    d3 = mk(1'b1, 4'h2, 1'b1);
    d4 = mk(1'b1, 4'h3, 1'b1);
    d5 = mk(1'b1, 4'h4, 1'b1);
    d6 = mk(1'b1, 4'h5, 1'b1);
    d7 = mk(1'b1, 4'h6, 1'b1);
    d8 = mk(1'b1, 4'h7, 1'b1);
    start_run(base);
    for (int k = 0; k < 8; k++)
      push(base + 6 * k + 2, ~(8'h01 << k), dec[k], 1'b1, 1'b0, "d_decode_lo");
    for (int k = 0; k < 8; k++)
      push(base + 48 + 6 * k + 3, ~(8'h01 << k), dec[k + 8], 1'b0, 1'b0, "d_decode_hi");
    wait_tick(base + 47);
    d1 = mk(1'b1, 4'h8, 1'b0);
    d2 = mk(1'b1, 4'h9, 1'b0);
    d3 = mk(1'b1, 4'hA, 1'b0);
    d4 = mk(1'b1, 4'hB, 1'b0);
    d5 = mk(1'b1, 4'hC, 1'b0);
    d6 = mk(1'b1, 4'hD, 1'b0);
    d7 = mk(1'b1, 4'hE, 1'b0);
    d8 = mk(1'b1, 4'hF, 1'b0);
    drain();

    // Reset mid-slot aborts and restarts the frame.
    set_all_enabled();
    start_run(base);
    for (int c = 8; c <= 9; c++) push(base + c, 8'hFD, 7'h24, 1'b1, 1'b0, "e_before_reset");
    wait_tick(base + 10);
    reset_i = 1'b1;
    push(base + 11, 8'hFF, 7'h7F, 1'b1, 1'b0, "e_reset_mid");
    @(negedge clk);
    reset_i = 1'b0;
    base2 = tick + 1;
    push(base2 + 0, 8'hFF, 7'h7F, 1'b1, 1'b1, "e_restart_frame");
    push(base2 + 1, 8'hFF, 7'h7F, 1'b1, 1'b0, "e_restart_blank");
    push(base2 + 2, 8'hFE, 7'h79, 1'b1, 1'b0, "e_restart_d1");
    drain();

    // Four frames of random inputs: BLANK is always dark, frame_o every 48.
    start_run(base);
    for (int c = 0; c < 192; c++)
      if (c % 6 < 2) push(base + c, 8'hFF, 7'h7F, 1'b1, (c % 48 == 0), "f_random_blank");
    for (int c = 0; c < 192; c++) begin
      d1 = 6'($urandom); d2 = 6'($urandom); d3 = 6'($urandom); d4 = 6'($urandom);
      d5 = 6'($urandom); d6 = 6'($urandom); d7 = 6'($urandom); d8 = 6'($urandom);
      lamp_test_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    lamp_test_i = 1'b0;
    drain();

    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
